// File: rtl/rc4_keystream_gen.sv
`default_nettype none
// ============================================================================
// Module   : rc4_keystream_gen
// Brief    : RC4 engine with runtime key length, optional drop[N] discard and
//            valid/ready handshakes on the key input and keystream output.
// Revision : 1.0 - initial release
// ============================================================================
module rc4_keystream_gen #(
  parameter int MAX_KEY_LEN = 16,
  parameter int DROP_N      = 0,
  parameter int KLW         = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [KLW-1:0] key_len_i,
  input  logic [7:0]     key_byte_i,
  input  logic           key_valid_i,
  output logic           key_ready_o,
  output logic [7:0]     ks_byte_o,
  output logic           ks_valid_o,
  input  logic           ks_ready_i,
  output logic           busy_o,
  output logic           key_err_o
);

  localparam int               c_kiw       = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1;
  localparam int               c_dcw       = (DROP_N > 1) ? $clog2(DROP_N) : 1;
  localparam logic [c_dcw-1:0] c_drop_last = c_dcw'((DROP_N > 0) ? (DROP_N - 1) : 0);
  localparam logic [KLW-1:0]   c_max_len   = KLW'(MAX_KEY_LEN);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_INIT = 3'd2,
    ST_KSA  = 3'd3,
    ST_DROP = 3'd4,
    ST_GEN  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       s_q [256];
  logic [7:0]       k_q [MAX_KEY_LEN];
  logic [KLW-1:0]   len_q;
  logic [KLW-1:0]   ld_cnt_q;
  logic [KLW-1:0]   kidx_q;
  logic [c_dcw-1:0] drop_cnt_q;
  logic [7:0]       i_q, j_q;
  logic [7:0]       ks_byte_q;
  logic             ks_valid_q;
  logic             key_err_q;

  logic             len_ok;
  logic             in_ksa;
  logic [7:0]       i_inc;
  logic [7:0]       idx_i;
  logic [7:0]       s_i;
  logic [7:0]       key_b;
  logic [7:0]       j_new;
  logic [7:0]       s_j;
  logic [7:0]       out_idx;
  logic [7:0]       s_out;
  logic             beat;
  logic             last_beat;
  logic             ksa_step;
  logic             prga_step;
  logic             gen_step;
  logic [KLW-1:0]   kidx_inc;

  // KSA reads S[i]; PRGA reads S[i+1]. Both then read S[j'] and, for PRGA,
  // the output tap S[S[i']+S[j']] -- all from the pre-swap array.
  always_comb begin
    len_ok    = (key_len_i != '0) && (key_len_i <= c_max_len);
    in_ksa    = (state_q == ST_KSA);
    i_inc     = i_q + 8'd1;
    idx_i     = in_ksa ? i_q : i_inc;
    s_i       = s_q[idx_i];
    key_b     = k_q[kidx_q[c_kiw-1:0]];
    j_new     = in_ksa ? (j_q + s_i + key_b) : (j_q + s_i);
    s_j       = s_q[j_new];
    out_idx   = s_i + s_j;
    s_out     = s_q[out_idx];
    kidx_inc  = kidx_q + KLW'(1);
    beat      = (state_q == ST_LOAD) && key_valid_i;
    last_beat = beat && ((ld_cnt_q + KLW'(1)) == len_q);
    ksa_step  = in_ksa && !start_i;
    gen_step  = !start_i && (state_q == ST_GEN) && (!ks_valid_q || ks_ready_i);
    prga_step = gen_step || (!start_i && (state_q == ST_DROP));
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      if (len_ok) state_d = ST_LOAD;
      else        state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_LOAD: if (last_beat) state_d = ST_INIT;
        ST_INIT: state_d = ST_KSA;
        ST_KSA: begin
          if (i_q == 8'hFF) begin
            if (DROP_N > 0) state_d = ST_DROP;
            else            state_d = ST_GEN;
          end
        end
        ST_DROP: if (drop_cnt_q == c_drop_last) state_d = ST_GEN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      ld_cnt_q   <= '0;
      kidx_q     <= '0;
      drop_cnt_q <= '0;
      i_q        <= 8'd0;
      j_q        <= 8'd0;
      ks_byte_q  <= 8'd0;
      ks_valid_q <= 1'b0;
      key_err_q  <= 1'b0;
      for (int n = 0; n < MAX_KEY_LEN; n++) k_q[n] <= 8'd0;
    end else begin
      state_q   <= state_d;
      key_err_q <= start_i && !len_ok;
      if (start_i) begin
        // Rekey aborts the session; an untaken keystream byte is discarded.
        ks_valid_q <= 1'b0;
        ks_byte_q  <= 8'd0;
        if (len_ok) begin
          len_q    <= key_len_i;
          ld_cnt_q <= '0;
        end
      end else begin
        case (state_q)
          ST_LOAD: begin
            if (beat) begin
              k_q[ld_cnt_q[c_kiw-1:0]] <= key_byte_i;
              ld_cnt_q                 <= ld_cnt_q + KLW'(1);
            end
          end
          ST_INIT: begin
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            kidx_q     <= '0;
            drop_cnt_q <= '0;
          end
          ST_KSA: begin
            i_q    <= i_inc;
            j_q    <= (i_q == 8'hFF) ? 8'd0 : j_new;
            kidx_q <= (kidx_inc == len_q) ? '0 : kidx_inc;
          end
          ST_DROP: begin
            i_q        <= i_inc;
            j_q        <= j_new;
            drop_cnt_q <= drop_cnt_q + c_dcw'(1);
          end
          ST_GEN: begin
            if (gen_step) begin
              i_q        <= i_inc;
              j_q        <= j_new;
              ks_byte_q  <= s_out;
              ks_valid_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Swapping S[x] with itself writes the same value twice, so i==j' is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 256; n++) s_q[n] <= 8'(n);
    end else if (!start_i && (state_q == ST_INIT)) begin
      for (int n = 0; n < 256; n++) s_q[n] <= 8'(n);
    end else if (ksa_step || prga_step) begin
      s_q[idx_i] <= s_j;
      s_q[j_new] <= s_i;
    end
  end

  assign key_ready_o = (state_q == ST_LOAD);
  assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_INIT) ||
                       (state_q == ST_KSA)  || (state_q == ST_DROP);
  assign ks_byte_o   = ks_byte_q;
  assign ks_valid_o  = ks_valid_q;
  assign key_err_o   = key_err_q;

endmodule
`default_nettype wire

// File: doc/rc4_keystream_gen.md
Name: rc4_keystream_gen

Overview:
Parametrised RC4 engine with three phases: key load, key scheduling (KSA), and keystream generation (PRGA). It adds three things a fixed key generator does not have: runtime key length, optional RC4-drop[N] discard, and valid/ready handshakes on both the key input and the keystream output. It sits between the key source and the byte-wise XOR datapath of the cipher.

Parameters:
MAX_KEY_LEN, 16, key buffer depth in bytes; legal range 1..256.
DROP_N, 0, number of initial keystream bytes generated and discarded before output; 0 disables the drop phase.
KLW, 9, width of key_len; must satisfy 2^KLW > MAX_KEY_LEN.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; begins a new key session and samples key_len.
key_len  in  KLW  key length in bytes; sampled only on start.
key_byte  in  8  key byte.
key_valid  in  1  key_byte is valid.
key_ready  out  1  block accepts key_byte.
ks_byte  out  8  keystream byte.
ks_valid  out  1  ks_byte is valid.
ks_ready  in  1  consumer accepts ks_byte.
busy  out  1  high in LOAD, INIT, KSA, and DROP.
key_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset values: key_ready=0, ks_valid=0, ks_byte=0, busy=0, key_err=0; state=IDLE; i=0, j=0; S[n]=n; key buffer cleared.
- State register holds one of IDLE, LOAD, INIT, KSA, DROP, GEN.
- IDLE:
  - start with 1<=key_len<=MAX_KEY_LEN: latch key_len, clear the load counter, go to LOAD.
  - start with any other key_len: pulse key_err, stay in IDLE.
- LOAD:
  - key_ready=1.
  - A beat is a cycle with key_valid&&key_ready; it stores key_byte at K[cnt], then cnt++.
  - After beat number key_len, go to INIT. key_ready falls in the cycle after the last beat.
- INIT: one cycle. S[n]<=n for all n, i<=0, j<=0, then go to KSA.
- KSA: 256 cycles, one iteration per cycle, i=0..255.
  - j' = j + S[i] + K[i mod key_len], mod 256.
  - Swap S[i] and S[j'] in the same cycle, reading pre-swap values. i==j' leaves S unchanged.
  - After i=255: i<=0, j<=0, then go to DROP if DROP_N>0, else go to GEN.
- PRGA step, used by both DROP and GEN:
  - i' = i+1; j' = j + S[i']; swap S[i'] and S[j'].
  - Output byte = S[(S[i'] + S[j']) mod 256], using pre-swap values.
- DROP: one PRGA step per cycle, output discarded; after DROP_N steps go to GEN.
- GEN:
  - The output register is loaded by a PRGA step whenever it is empty or being consumed (!ks_valid || ks_ready).
  - This gives full throughput of 1 byte/cycle while ks_ready=1.
  - ks_byte and ks_valid stay stable while ks_valid&&!ks_ready; no step advances while stalled.
  - First ks_valid occurs 1 cycle after entering GEN.
- Latency from the last key beat to the first ks_valid is 1 + 256 + DROP_N + 1 cycles.
- The i, j, and key counter arithmetic is mod 256. i and j wrap 255->0 silently. GEN is unbounded.
- start in any state other than IDLE acts as a rekey:
  - Abort the session immediately and drop ks_valid the next cycle; an un-taken byte is lost.
  - Go to LOAD (key_len legal) or to IDLE with a key_err pulse (key_len illegal).
- key_valid outside LOAD is ignored. ks_ready outside GEN is ignored.
- Asserting rst mid-operation returns every output and all state to the reset values immediately. The S reinit is not required to complete.
- busy=1 in LOAD, INIT, KSA, and DROP; busy=0 in IDLE and GEN.

Test Plan:
1. Reset, start with key_len=3, key "Key" (4B 65 79), ks_ready=1 -> ks_byte sequence EB 9F 77 81 B7 34 CA 72 A7 19; first ks_valid exactly 258 cycles after the last key beat.
2. Key "Wiki" (57 69 6B 69), then key "Secret" (53 65 63 72 65 74) via a rekey start mid-GEN -> 60 44 DB 6D 41 B7, then after rekey 04 D4 6B 05 3C A8 7B 59; no stale byte appears after the rekey.
3. Instance with DROP_N=3, key "Key" -> first output 81, then B7 34 CA; latency 261 cycles.
4. Key "Key", random ks_ready backpressure and random key_valid gaps -> byte stream identical to scenario 1; ks_byte stable during stalls; key_ready never accepts a 4th beat.
5. start with key_len=0, and start with key_len=MAX_KEY_LEN+1 -> key_err one-cycle pulse each, state remains IDLE, key_ready=0; a key_len=MAX_KEY_LEN key is accepted and KSA runs.
6. rst asserted during KSA and again during GEN with ks_valid=1 -> all outputs 0 asynchronously; a fresh "Key" session afterwards reproduces EB 9F 77....
